// File: rtl/xbar_pkg.sv
// rtl/xbar_pkg.sv - shared constants, index wrap helper and lane register type for crossbar_rr
package xbar_pkg;

  localparam int XBAR_DATA_W = 16;
  localparam int XBAR_N      = 6;
  localparam int XBAR_M      = 4;
  localparam int XBAR_ID_W   = $clog2(XBAR_N);

  // One output lane as held in the register bank
  typedef struct packed {
    logic                   valid;
    logic [XBAR_ID_W-1:0]   id;
    logic [XBAR_DATA_W-1:0] data;
  } lane_t;

  // Modulo-n increment; exact for non-power-of-2 n
  function automatic int idx_wrap(input int a, input int n);
    return (a >= n - 1) ? 0 : a + 1;
  endfunction

endpackage

// File: rtl/crossbar_rr_select.sv
// rtl/crossbar_rr_select.sv - combinational scan from ptr granting up to M valid inputs, packed in scan order
module crossbar_rr_select
  import xbar_pkg::*;
#(
  parameter int N    = XBAR_N,
  parameter int M    = XBAR_M,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    ivalid,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [M-1:0]    lane_valid,
  output logic [ID_W-1:0] lane_src [M]
);

  localparam int LW = (M > 1) ? $clog2(M) : 1;

  // Walk the inputs starting at ptr; each valid input takes the next free lane until M are used
  always_comb begin
    int cnt;
    int idx;
    cnt        = 0;
    idx        = 0;
    grant      = '0;
    lane_valid = '0;
    for (int j = 0; j < M; j++) lane_src[j] = '0;
    for (int o = 0; o < N; o++) begin
      idx = int'(ptr) + o;
      if (idx >= N) idx = idx - N;
      if (ivalid[ID_W'(idx)] && (cnt < M)) begin
        grant[ID_W'(idx)]     = 1'b1;
        lane_valid[LW'(cnt)]  = 1'b1;
        lane_src[LW'(cnt)]    = ID_W'(idx);
        cnt                   = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/crossbar_rr.sv
// rtl/crossbar_rr.sv - registered handshaked N-to-M compaction crossbar; XBAR_ROUND_ROBIN_EN enables the rotating start pointer
module crossbar_rr
  import xbar_pkg::*;
#(
  parameter  int DATA_W = XBAR_DATA_W,
  parameter  int N      = XBAR_N,
  parameter  int M      = XBAR_M,
  localparam int ID_W   = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      ivalid,
  input  logic [DATA_W-1:0] idata [N],
  output logic [N-1:0]      iready,
  output logic [M-1:0]      ovalid,
  output logic [DATA_W-1:0] odata [M],
  output logic [ID_W-1:0]   oid [M],
  input  logic              oready
);

  logic [N-1:0]    w_grant;
  logic [M-1:0]    w_lane_valid;
  logic [ID_W-1:0] w_lane_src [M];
  logic [ID_W-1:0] w_ptr;
  logic [ID_W-1:0] w_last;
  logic [M-1:0]    w_out_valid;
  logic            w_load;
  lane_t           r_lane [M];

  crossbar_rr_select #(
    .N    (N),
    .M    (M),
    .ID_W (ID_W)
  ) u_select (
    .ivalid     (ivalid),
    .ptr        (w_ptr),
    .grant      (w_grant),
    .lane_valid (w_lane_valid),
    .lane_src   (w_lane_src)
  );

  // Gather the lane valid bits held in the register bank
  always_comb begin
    w_out_valid = '0;
    for (int j = 0; j < M; j++) w_out_valid[j] = r_lane[j].valid;
  end

  // The bank reloads when empty or when downstream takes the whole vector
  assign w_load = !(|w_out_valid) || oready;
  assign iready = (w_load && rst_n) ? w_grant : '0;

  // Highest occupied lane holds the last granted input in scan order
  always_comb begin
    w_last = '0;
    for (int j = 0; j < M; j++) begin
      if (w_lane_valid[j]) w_last = w_lane_src[j];
    end
  end

  // Output register bank; unused lanes are cleared so stale ids never leak out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < M; j++) r_lane[j] <= '0;
    end else if (w_load) begin
      for (int j = 0; j < M; j++) begin
        if (w_lane_valid[j]) begin
          r_lane[j].valid <= 1'b1;
          r_lane[j].id    <= XBAR_ID_W'(w_lane_src[j]);
          r_lane[j].data  <= XBAR_DATA_W'(idata[w_lane_src[j]]);
        end else begin
          r_lane[j] <= '0;
        end
      end
    end
  end

  // Present the register bank at the configured widths
  always_comb begin
    for (int j = 0; j < M; j++) begin
      odata[j] = DATA_W'(r_lane[j].data);
      oid[j]   = ID_W'(r_lane[j].id);
    end
  end

  assign ovalid = w_out_valid;

`ifdef XBAR_ROUND_ROBIN_EN
  logic [ID_W-1:0] r_ptr;

  // Next scan starts just past the last input served; idle load cycles keep the pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_load && w_lane_valid[0]) begin
      r_ptr <= ID_W'(idx_wrap(int'(w_last), N));
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

endmodule

// File: tb/tb_crossbar_rr.sv
// tb/tb_crossbar_rr.sv - directed and random scoreboard bench for crossbar_rr
module tb_crossbar_rr;

  localparam int DATA_W = 16;
  localparam int N      = 6;
  localparam int M      = 4;
  localparam int ID_W   = 3;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      ivalid;
  logic [DATA_W-1:0] idata [N];
  logic [N-1:0]      iready;
  logic [M-1:0]      ovalid;
  logic [DATA_W-1:0] odata [M];
  logic [ID_W-1:0]   oid [M];
  logic              oready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  crossbar_rr #(.DATA_W(DATA_W), .N(N), .M(M)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ivalid (ivalid),
    .idata  (idata),
    .iready (iready),
    .ovalid (ovalid),
    .odata  (odata),
    .oid    (oid),
    .oready (oready)
  );

  task automatic set_default_data();
    for (int i = 0; i < N; i++) idata[i] = 16'(17 * (i + 1));
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    ivalid = '0;
    oready = 1'b0;
    set_default_data();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_default_data();
    rst_n  = 1'b0;
    ivalid = '1;
    oready = 1'b0;
    @(negedge clk);
    n_cmp++; if (ovalid !== 4'b0000) begin n_bad++; $display("FAIL reset_ovalid: got %b expected %b", ovalid, 4'b0000); end
    n_cmp++; if (iready !== 6'b000000) begin n_bad++; $display("FAIL reset_iready: got %b expected %b", iready, 6'b000000); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (ovalid !== 4'b1111) begin n_bad++; $display("FAIL reset_fill: got %b expected %b", ovalid, 4'b1111); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ovalid !== 4'b0000) begin n_bad++; $display("FAIL reset_async_ovalid: got %b expected %b", ovalid, 4'b0000); end
    n_cmp++; if (iready !== 6'b000000) begin n_bad++; $display("FAIL reset_async_iready: got %b expected %b", iready, 6'b000000); end
    for (int j = 0; j < M; j++) begin
      n_cmp++; if (odata[j] !== 16'h0000) begin n_bad++; $display("FAIL reset_odata[%0d]: got %h expected %h", j, odata[j], 16'h0000); end
      n_cmp++; if (oid[j] !== 3'd0) begin n_bad++; $display("FAIL reset_oid[%0d]: got %0d expected %0d", j, oid[j], 0); end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] e_rdy [3];
    int           e_id  [3][4];
`ifdef XBAR_ROUND_ROBIN_EN
    e_rdy = '{6'b001111, 6'b110011, 6'b111100};
    e_id  = '{'{0, 1, 2, 3}, '{4, 5, 0, 1}, '{2, 3, 4, 5}};
`else
    e_rdy = '{6'b001111, 6'b001111, 6'b001111};
    e_id  = '{'{0, 1, 2, 3}, '{0, 1, 2, 3}, '{0, 1, 2, 3}};
`endif
    do_reset();
    ivalid = '1;
    oready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (iready !== e_rdy[c]) begin n_bad++; $display("FAIL rr_iready c%0d: got %b expected %b", c, iready, e_rdy[c]); end
      @(posedge clk);
      #1;
      n_cmp++; if (ovalid !== 4'b1111) begin n_bad++; $display("FAIL rr_ovalid c%0d: got %b expected %b", c, ovalid, 4'b1111); end
      for (int j = 0; j < M; j++) begin
        n_cmp++; if (oid[j] !== 3'(e_id[c][j])) begin n_bad++; $display("FAIL rr_oid c%0d lane%0d: got %0d expected %0d", c, j, oid[j], e_id[c][j]); end
        n_cmp++; if (odata[j] !== 16'(17 * (e_id[c][j] + 1))) begin n_bad++; $display("FAIL rr_odata c%0d lane%0d: got %h expected %h", c, j, odata[j], 16'(17 * (e_id[c][j] + 1))); end
      end
    end
  endtask

  task automatic test_sparse();
    do_reset();
    ivalid = 6'b100100;
    oready = 1'b1;
    @(negedge clk);
    n_cmp++; if (iready !== 6'b100100) begin n_bad++; $display("FAIL sparse_iready: got %b expected %b", iready, 6'b100100); end
    @(posedge clk);
    #1;
    n_cmp++; if (ovalid !== 4'b0011) begin n_bad++; $display("FAIL sparse_ovalid: got %b expected %b", ovalid, 4'b0011); end
    n_cmp++; if (oid[0] !== 3'd2) begin n_bad++; $display("FAIL sparse_oid0: got %0d expected %0d", oid[0], 2); end
    n_cmp++; if (odata[0] !== 16'h0033) begin n_bad++; $display("FAIL sparse_odata0: got %h expected %h", odata[0], 16'h0033); end
    n_cmp++; if (oid[1] !== 3'd5) begin n_bad++; $display("FAIL sparse_oid1: got %0d expected %0d", oid[1], 5); end
    n_cmp++; if (odata[1] !== 16'h0066) begin n_bad++; $display("FAIL sparse_odata1: got %h expected %h", odata[1], 16'h0066); end
    n_cmp++; if (odata[2] !== 16'h0000) begin n_bad++; $display("FAIL sparse_odata2_zero: got %h expected %h", odata[2], 16'h0000); end
    ivalid = '1;
    @(negedge clk);
    n_cmp++; if (iready !== 6'b001111) begin n_bad++; $display("FAIL sparse_ptr_wrap_iready: got %b expected %b", iready, 6'b001111); end
    @(posedge clk);
    #1;
    for (int j = 0; j < M; j++) begin
      n_cmp++; if (oid[j] !== 3'(j)) begin n_bad++; $display("FAIL sparse_ptr_wrap_oid%0d: got %0d expected %0d", j, oid[j], j); end
    end
  endtask

  task automatic test_back_pressure();
    logic [N-1:0] e_rdy;
    int           e_id [4];
`ifdef XBAR_ROUND_ROBIN_EN
    e_rdy = 6'b110011;
    e_id  = '{4, 5, 0, 1};
`else
    e_rdy = 6'b001111;
    e_id  = '{0, 1, 2, 3};
`endif
    do_reset();
    ivalid = '1;
    oready = 1'b0;
    @(negedge clk);
    n_cmp++; if (iready !== 6'b001111) begin n_bad++; $display("FAIL bp_fill_iready: got %b expected %b", iready, 6'b001111); end
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (iready !== 6'b000000) begin n_bad++; $display("FAIL bp_hold_iready c%0d: got %b expected %b", c, iready, 6'b000000); end
      n_cmp++; if (ovalid !== 4'b1111) begin n_bad++; $display("FAIL bp_hold_ovalid c%0d: got %b expected %b", c, ovalid, 4'b1111); end
      for (int j = 0; j < M; j++) begin
        n_cmp++; if (oid[j] !== 3'(j)) begin n_bad++; $display("FAIL bp_hold_oid c%0d lane%0d: got %0d expected %0d", c, j, oid[j], j); end
      end
      n_cmp++; if (odata[3] !== 16'h0044) begin n_bad++; $display("FAIL bp_hold_odata3 c%0d: got %h expected %h", c, odata[3], 16'h0044); end
    end
    @(posedge clk);
    #1;
    oready = 1'b1;
    @(negedge clk);
    n_cmp++; if (iready !== e_rdy) begin n_bad++; $display("FAIL bp_release_iready: got %b expected %b", iready, e_rdy); end
    @(posedge clk);
    #1;
    n_cmp++; if (ovalid !== 4'b1111) begin n_bad++; $display("FAIL bp_reload_ovalid: got %b expected %b", ovalid, 4'b1111); end
    for (int j = 0; j < M; j++) begin
      n_cmp++; if (oid[j] !== 3'(e_id[j])) begin n_bad++; $display("FAIL bp_reload_oid lane%0d: got %0d expected %0d", j, oid[j], e_id[j]); end
    end
    ivalid = '0;
    @(posedge clk);
    #1;
    n_cmp++; if (ovalid !== 4'b0000) begin n_bad++; $display("FAIL bp_empty_ovalid: got %b expected %b", ovalid, 4'b0000); end
    n_cmp++; if (odata[0] !== 16'h0000) begin n_bad++; $display("FAIL bp_empty_odata0: got %h expected %h", odata[0], 16'h0000); end
  endtask

  task automatic test_random();
    ent_t         sb [$];
    logic [N-1:0] pend;
    logic [N-1:0] acc;
    logic [M-1:0] ov1;
    int           wt [N];
    int           seqn;
    int           fk;
    int           nv;
    int           exp_n;
    logic         ld;
    do_reset();
    pend = '0;
    seqn = 0;
    for (int i = 0; i < N; i++) wt[i] = 0;
    for (int cyc = 0; cyc < 1210; cyc++) begin
      if (cyc < 1200) begin
        for (int i = 0; i < N; i++) begin
          if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
            pend[i]  = 1'b1;
            idata[i] = {3'(i), 13'(seqn)};
            seqn++;
          end
        end
        oready = ($urandom_range(0, 9) < 7);
      end else begin
        oready = 1'b1;
      end
      ivalid = pend;
      @(negedge clk);
      if (oready) begin
        for (int j = 0; j < M; j++) begin
          if (ovalid[j]) begin
            fk = -1;
            for (int k = 0; k < sb.size(); k++) begin
              if (fk < 0 && sb[k].id == oid[j]) fk = k;
            end
            n_cmp++;
            if (fk < 0) begin
              n_bad++; $display("FAIL rand_unexpected cyc%0d lane%0d: got id %0d data %h expected no word", cyc, j, oid[j], odata[j]);
            end else begin
              if (sb[fk].data !== odata[j]) begin n_bad++; $display("FAIL rand_data cyc%0d lane%0d: got %h expected %h", cyc, j, odata[j], sb[fk].data); end
              sb.delete(fk);
            end
          end
        end
      end
      ov1 = ovalid + 4'd1;
      n_cmp++; if ((ovalid & ov1) !== 4'b0000) begin n_bad++; $display("FAIL rand_packing cyc%0d: got %b expected contiguous from lane 0", cyc, ovalid); end
      ld  = !(|ovalid) || oready;
      acc = ivalid & iready;
      nv  = $countones(ivalid);
      exp_n = ld ? ((nv < M) ? nv : M) : 0;
      n_cmp++; if ((iready & ~ivalid) !== 6'b000000) begin n_bad++; $display("FAIL rand_iready_no_req cyc%0d: got %b expected subset of %b", cyc, iready, ivalid); end
      n_cmp++; if ($countones(acc) != exp_n) begin n_bad++; $display("FAIL rand_grant_count cyc%0d: got %0d expected %0d", cyc, $countones(acc), exp_n); end
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          sb.push_back({3'(i), idata[i]});
          pend[i] = 1'b0;
        end
`ifdef XBAR_ROUND_ROBIN_EN
        if (ld && ivalid[i]) begin
          if (acc[i]) wt[i] = 0;
          else begin
            wt[i]++;
            n_cmp++; if (wt[i] > 3) begin n_bad++; $display("FAIL rand_starve cyc%0d in%0d: got wait %0d expected at most %0d", cyc, i, wt[i], 3); end
          end
        end
`endif
      end
      @(posedge clk);
      #1;
    end
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL rand_drain: got %0d words left expected %0d", sb.size(), 0); end
    n_cmp++; if (pend !== 6'b000000) begin n_bad++; $display("FAIL rand_pending: got %b expected %b", pend, 6'b000000); end
  endtask

  initial begin
    rst_n  = 1'b0;
    ivalid = '0;
    oready = 1'b0;
    set_default_data();
    test_reset();
    test_round_robin();
    test_sparse();
    test_back_pressure();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before %0d ns", 200000);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/crossbar_rr.md
Name: crossbar_rr

Overview:
- Registered, handshaked successor to the combinational N-to-M compaction crossbar.
- Each cycle it selects up to M valid inputs, scanning from a round-robin start pointer. It packs their data, in scan order, onto outputs 0..k-1 and registers the result together with the source index.
- Inputs not selected are back-pressured through iready instead of being dropped, which removes the starvation of high-index inputs present in the fixed-priority version.
- Sits between N request sources and an M-lane downstream consumer.

Parameters:
- DATA_W, 16, payload width per channel.
- N, 6, number of input channels; N >= 2.
- M, 4, number of output lanes; 1 <= M <= N.
- ID_W, $clog2(N), localparam; width of a source index.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ivalid  in  N  per-input request valid
- idata  in  N x DATA_W (unpacked [N])  per-input payload
- iready  out  N  per-input accept; transfer on input i when ivalid[i] && iready[i]
- ovalid  out  M  registered lane valid
- odata  out  M x DATA_W (unpacked [M])  registered lane payload
- oid  out  M x ID_W (unpacked [M])  registered source index of each lane
- oready  in  1  downstream accepts the whole output vector this cycle

Behaviour:
- Reset (async assert, sync release):
  - ovalid = 0, odata = 0, oid = 0, ptr = 0.
  - iready = 0 while rst_n is low.
- Output stage is one register bank.
  - load = !(|ovalid) || oready.
  - When load = 0, every iready = 0 and all outputs and ptr hold.
- Selection, combinational, when load = 1:
  - Scan inputs in order ptr, ptr+1, ..., ptr+N-1, all mod N.
  - The first min(M, popcount(ivalid)) valid inputs are granted.
  - The j-th granted input drives lane j.
  - iready[i] = grant[i]; iready may depend combinationally on ivalid.
- Capture on the clock edge when load = 1:
  - Lane j < k: ovalid[j] = 1, odata[j] = idata[src], oid[j] = src.
  - Lane j >= k: ovalid[j] = 0; odata/oid are don't-care, but are zeroed.
  - k = 0 with oready = 1: stage empties (all ovalid = 0).
- Pointer update:
  - If k > 0: ptr <= (last granted index + 1) mod N.
  - If k = 0: ptr holds.
  - Wrap from N-1 to 0 must be exact for non-power-of-2 N; no ID_W overflow.
- Latency: 1 cycle from input handshake to ovalid; throughput is M words per cycle when oready stays high.
- Input protocol: once ivalid[i] is high it stays high with stable idata until accepted. The block does not check this.
- Simultaneous oready = 1 with stage full and new requests: unload and reload in the same cycle, with no bubble.
- Fewer than M requesters: all are granted in the same cycle.
- Reset mid-operation: in-flight lanes are discarded immediately and not replayed.

Optional Feature:
- Macro: XBAR_ROUND_ROBIN_EN.
- Defined: rotating ptr, as described in Behaviour.
- Undefined:
  - ptr is constant 0, giving fixed priority (input 0 highest).
  - No ptr register is synthesised.
  - Packing order is otherwise identical, i.e. the legacy compaction order.

Decomposition:
- Package xbar_pkg holds:
  - the default DATA_W/N/M constants;
  - the function idx_wrap(a, N) for modulo increment;
  - a packed typedef lane_t {valid, id, data} used for the output register bank.
- Sub-module crossbar_rr_select (purely combinational), with parameters N, M, ID_W:
  - inputs: ivalid and ptr;
  - outputs: grant[N], lane_valid[M] and lane_src[M].
- crossbar_rr instantiates crossbar_rr_select and owns the registers, handshake and ptr.

Test Plan (N=6, M=4, DATA_W=16, idata[i]=16'h0011*(i+1) unless stated):
- Reset: rst_n=0 mid-stream with ovalid=4'b1111 → ovalid, odata and oid are 0 asynchronously; ptr=0 after release; iready=0 during reset.
- Round-robin (macro on), ivalid=6'b111111 held, oready=1:
  - cycle 1: oid={0,1,2,3}, ptr=4;
  - cycle 2: oid={4,5,0,1}, ptr=2;
  - cycle 3: oid={2,3,4,5}.
- Sparse, ptr=0, ivalid=6'b100100 → iready=6'b100100; next cycle ovalid=4'b0011, oid[0]=2, odata[0]=16'h0033, oid[1]=5, odata[1]=16'h0066, ptr=0.
- Backpressure: stage full, oready=0 for 3 cycles → iready=0, and outputs and ptr stable. Then oready=1 → same-cycle reload with no bubble.
- Fixed priority (macro off), ivalid=6'b111111 held → oid={0,1,2,3} every cycle; iready[5:4] stays 0.
- Random scoreboard (≥1000 cycles, random ivalid/oready):
  - every accepted input word appears exactly once on a lane with the matching oid;
  - lanes are packed contiguously from lane 0;
  - with the macro on, no input waits more than ceil(N/M)+1 load cycles.
